data_access_unit_m: RTL and testbench

Load/store stage for the multi-cycle core: accepts one data-memory request from execute, drives the memory controller's second read port (`rd_*[1]`) and its write port, waits for completion, and returns read data plus a one-cycle completion/error pulse. It is the data-side counterpart of the instruction fetch unit, which owns read port 0. It shares the memory controller with fetch but never touches port 0.

---
 rtl/data_access_unit_m.sv | 215 +++++++++++++++++++++
 tb/tb_data_access_unit_m.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/data_access_unit_m.sv
// ============================================================================
// data_access_unit_m
// ----------------------------------------------------------------------------
// Load/store stage of the multi-cycle core. Accepts one data-memory request
// from execute, drives read port 1 and the write port of the shared memory
// controller, waits for completion and returns a one-cycle done pulse with
// err/misalign status plus the load result. Read port 0 belongs to fetch and
// is never touched here.
//
// Optional feature macro: DAU_ALIGN_CHECK_EN
//   defined   : odd-address word accesses fault locally (IDLE -> RESP, no
//               controller access, err=1, misalign=1, load rdata cleared).
//   undefined : odd word addresses pass through unchanged; misalign tied 0.
//
// Ports
//   clk, reset        : clock (rising edge), async active-high reset
//   req/we/size/addr/wdata : request from execute (sampled only in IDLE)
//   busy              : high whenever not IDLE
//   done/err/misalign : one-cycle completion pulse with status
//   rdata             : load result, held until the next done
//   rd_en/rd_size/rd_addr, rd_done/rd_data/invalid_rd_addr : read port 1
//   wr_en/wr_size/wr_addr/wr_data, invalid_wr_addr         : write port
// ============================================================================
module data_access_unit_m (
    input  logic        clk,
    input  logic        reset,
    // execute side
    input  logic        req,
    input  logic        we,
    input  logic        size,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        misalign,
    output logic [15:0] rdata,
    // controller read port 1
    output logic        rd_en,
    output logic        rd_size,
    output logic [15:0] rd_addr,
    input  logic        rd_done,
    input  logic [15:0] rd_data,
    input  logic        invalid_rd_addr,
    // controller write port
    output logic        wr_en,
    output logic        wr_size,
    output logic [15:0] wr_addr,
    output logic [15:0] wr_data,
    input  logic        invalid_wr_addr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // latched request; the direction is encoded by RD/WR so no we copy is kept
    logic        r_size_q;
    logic [15:0] r_addr_q;
    logic [15:0] r_wdata_q;

    logic        r_err;
    logic [15:0] r_rdata;
    logic        w_misalign_req;

`ifdef DAU_ALIGN_CHECK_EN
    logic        r_misalign;

    assign w_misalign_req = size & addr[0];
    assign misalign       = r_misalign;
`else
    assign w_misalign_req = 1'b0;
    assign misalign       = 1'b0;
`endif

    assign err   = r_err;
    assign rdata = r_rdata;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and port outputs. Enables are decoded from the state
    // register so an asynchronous reset drops them immediately.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b1;
        done        = 1'b0;
        rd_en       = 1'b0;
        rd_size     = 1'b0;
        rd_addr     = '0;
        wr_en       = 1'b0;
        wr_size     = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;

        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (req) begin
                    if (w_misalign_req) begin
                        w_state_nxt = S_RESP;
                    end else if (we) begin
                        w_state_nxt = S_WR;
                    end else begin
                        w_state_nxt = S_RD;
                    end
                end
            end

            S_RD: begin
                rd_en   = 1'b1;
                rd_size = r_size_q;
                rd_addr = r_addr_q;
                if (invalid_rd_addr || rd_done) begin
                    w_state_nxt = S_RESP;
                end
            end

            S_WR: begin
                wr_en       = 1'b1;
                wr_size     = r_size_q;
                wr_addr     = r_addr_q;
                wr_data     = r_wdata_q;
                w_state_nxt = S_RESP;
            end

            S_RESP: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_size_q   <= 1'b0;
            r_addr_q   <= '0;
            r_wdata_q  <= '0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
`ifdef DAU_ALIGN_CHECK_EN
            r_misalign <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_size_q  <= size;
                        r_addr_q  <= addr;
                        r_wdata_q <= wdata;
`ifdef DAU_ALIGN_CHECK_EN
                        if (w_misalign_req) begin
                            r_err      <= 1'b1;
                            r_misalign <= 1'b1;
                            if (!we) begin
                                r_rdata <= '0;
                            end
                        end
`endif
                    end
                end

                S_RD: begin
                    // a fault wins over a coincident completion
                    if (invalid_rd_addr) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end else if (rd_done) begin
                        r_err   <= 1'b0;
                        r_rdata <= r_size_q ? rd_data : {8'h00, rd_data[7:0]};
                    end
                end

                S_WR: begin
                    r_err <= invalid_wr_addr;
                end

                S_RESP: begin
                    r_err      <= 1'b0;
`ifdef DAU_ALIGN_CHECK_EN
                    r_misalign <= 1'b0;
`endif
                end

                default: begin
                    r_err <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_access_unit_m.sv
module tb_data_access_unit_m;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, we, size;
    logic [15:0] addr, wdata;
    logic        busy, done, err, misalign;
    logic [15:0] rdata;
    logic        rd_en, rd_size;
    logic [15:0] rd_addr;
    logic        rd_done;
    logic [15:0] rd_data;
    logic        invalid_rd_addr;
    logic        wr_en, wr_size;
    logic [15:0] wr_addr, wr_data;
    logic        invalid_wr_addr;

    data_access_unit_m dut (
        .clk             (clk),
        .reset           (reset),
        .req             (req),
        .we              (we),
        .size            (size),
        .addr            (addr),
        .wdata           (wdata),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .misalign        (misalign),
        .rdata           (rdata),
        .rd_en           (rd_en),
        .rd_size         (rd_size),
        .rd_addr         (rd_addr),
        .rd_done         (rd_done),
        .rd_data         (rd_data),
        .invalid_rd_addr (invalid_rd_addr),
        .wr_en           (wr_en),
        .wr_size         (wr_size),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .invalid_wr_addr (invalid_wr_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic        mis;
        logic [15:0] rdata;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_rdata;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation
    always @(negedge clk) begin
        if (!reset && done === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_err", {15'd0, err}, {15'd0, e.err});
                chk("done_misalign", {15'd0, misalign}, {15'd0, e.mis});
                chk("done_rdata", rdata, e.rdata);
                chk("done_cycle", cyc[15:0], e.cyc[15:0]);
            end
        end
    end

    task automatic push(input logic e_err, input logic e_mis, input logic [15:0] e_rd, input int e_cyc);
        exp_t e;
        e.err   = e_err;
        e.mis   = e_mis;
        e.rdata = e_rd;
        e.cyc   = e_cyc;
        sb.push_back(e);
    endtask

    task automatic store(input logic [15:0] a, input logic [15:0] d, input logic sz, input logic inv);
        int n;
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = sz; addr = a; wdata = d;
        n = cyc + 1;
        push(inv, 1'b0, exp_rdata, n + 1);
        @(negedge clk);
        req = 1'b0;
        invalid_wr_addr = inv;
        chk("wr_en", {15'd0, wr_en}, 16'd1);
        chk("wr_addr", wr_addr, a);
        chk("wr_size", {15'd0, wr_size}, {15'd0, sz});
        chk("wr_data", wr_data, d);
        chk("wr_busy", {15'd0, busy}, 16'd1);
        chk("wr_no_rd_en", {15'd0, rd_en}, 16'd0);
        @(negedge clk);
        invalid_wr_addr = 1'b0;
        chk("wr_en_one_cycle", {15'd0, wr_en}, 16'd0);
        chk("wr_addr_idle", wr_addr, 16'h0000);
    endtask

    task automatic load(input logic [15:0] a, input logic sz, input int lat, input logic [15:0] mem,
                        input logic inv, input logic [15:0] exp_rd);
        int n;
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = sz; addr = a;
        n = cyc + 1;
        push(inv, 1'b0, exp_rd, n + lat);
        exp_rdata = exp_rd;
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            req = 1'b0;
            chk("rd_en", {15'd0, rd_en}, 16'd1);
            chk("rd_addr", rd_addr, a);
            chk("rd_size", {15'd0, rd_size}, {15'd0, sz});
            chk("rd_no_wr_en", {15'd0, wr_en}, 16'd0);
            if (i == lat) begin
                rd_done = 1'b1;
                rd_data = mem;
                invalid_rd_addr = inv;
            end
        end
        @(negedge clk);
        rd_done = 1'b0;
        rd_data = 16'h0000;
        invalid_rd_addr = 1'b0;
        chk("rd_en_off", {15'd0, rd_en}, 16'd0);
        chk("rd_addr_idle", rd_addr, 16'h0000);
    endtask

    initial begin
        reset = 1'b1;
        req = 1'b0; we = 1'b0; size = 1'b0; addr = '0; wdata = '0;
        rd_done = 1'b0; rd_data = '0; invalid_rd_addr = 1'b0; invalid_wr_addr = 1'b0;
        exp_rdata = 16'h0000;
        repeat (2) @(negedge clk);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_done", {15'd0, done}, 16'd0);
        chk("rst_err", {15'd0, err}, 16'd0);
        chk("rst_misalign", {15'd0, misalign}, 16'd0);
        chk("rst_rdata", rdata, 16'h0000);
        chk("rst_rd_en", {15'd0, rd_en}, 16'd0);
        chk("rst_rd_size", {15'd0, rd_size}, 16'd0);
        chk("rst_rd_addr", rd_addr, 16'h0000);
        chk("rst_wr_en", {15'd0, wr_en}, 16'd0);
        chk("rst_wr_size", {15'd0, wr_size}, 16'd0);
        chk("rst_wr_addr", wr_addr, 16'h0000);
        chk("rst_wr_data", wr_data, 16'h0000);
        reset = 1'b0;

        store(16'h0100, 16'hBEEF, 1'b1, 1'b0);
        load(16'h0100, 1'b1, 3, 16'hBEEF, 1'b0, 16'hBEEF);
        load(16'h0101, 1'b0, 1, 16'h12AB, 1'b0, 16'h00AB);
        store(16'h0201, 16'h77CC, 1'b0, 1'b0);
        store(16'hFF00, 16'h1234, 1'b1, 1'b1);
        load(16'hFF02, 1'b1, 2, 16'h5678, 1'b1, 16'h0000);
        load(16'h0020, 1'b1, 1, 16'hC3A5, 1'b0, 16'hC3A5);

`ifdef DAU_ALIGN_CHECK_EN
        begin
            int n;
            @(negedge clk);
            req = 1'b1; we = 1'b0; size = 1'b1; addr = 16'h0003;
            n = cyc + 1;
            push(1'b1, 1'b1, 16'h0000, n);
            exp_rdata = 16'h0000;
            @(negedge clk);
            req = 1'b0;
            chk("mis_no_rd_en", {15'd0, rd_en}, 16'd0);
            chk("mis_no_wr_en", {15'd0, wr_en}, 16'd0);
        end
`else
        load(16'h0003, 1'b1, 1, 16'h5A5A, 1'b0, 16'h5A5A);
`endif

        // reset while a load is outstanding
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 1'b1; addr = 16'h0040;
        @(negedge clk);
        req = 1'b0;
        chk("pre_rst_rd_en", {15'd0, rd_en}, 16'd1);
        reset = 1'b1;
        #1;
        chk("midrst_rd_en", {15'd0, rd_en}, 16'd0);
        chk("midrst_busy", {15'd0, busy}, 16'd0);
        chk("midrst_done", {15'd0, done}, 16'd0);
        chk("midrst_rdata", rdata, 16'h0000);
        exp_rdata = 16'h0000;
        @(negedge clk);
        reset = 1'b0;
        chk("post_rst_busy", {15'd0, busy}, 16'd0);

        load(16'h0100, 1'b1, 2, 16'hBEEF, 1'b0, 16'hBEEF);
        store(16'h0300, 16'hA1B2, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size()[15:0], 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
